mult_seq: RTL and testbench
===========================

// Module: mult_seq
// PURPOSE
//   Parametrised sequential shift-add multiplier for the datapath HI/LO unit.
//   Serves both MULT (signed) and MULTU (unsigned) through a per-operation mode bit.
//   Runs single-edge (posedge only) with a start/busy/done handshake.
//   Optional early termination ends the operation once the remaining multiplier bits are zero.
// PARAMETERS
//   WIDTH     32  operand width in bits; product is 2*WIDTH bits (hi = upper, lo = lower)
//   EARLY_OUT 1   1: finish when the remaining shifted multiplier is zero; 0: fixed WIDTH iterations
// PORTS
//   clock         in   1        system clock, all state updates on posedge
//   reset_n       in   1        synchronous reset, active-low
//   start         in   1        launch operation; sampled only in IDLE or DONE
//   is_signed     in   1        1 = two's-complement operands (MULT), 0 = unsigned (MULTU)
//   multiplicand  in   WIDTH    operand A, captured on accepted start
//   multiplier    in   WIDTH    operand B, captured on accepted start
//   busy          out  1        high in RUN and FIX
//   done          out  1        one-cycle pulse in DONE; hi/lo valid from this cycle
//   hi            out  WIDTH    product[2*WIDTH-1:WIDTH], registered
//   lo            out  WIDTH    product[WIDTH-1:0], registered
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): state=IDLE; busy=0; done=0; hi=0; lo=0; internal regs=0.
//     Reset wins over every other input. Reset mid-RUN/FIX aborts the operation; no done pulse.
//   States: IDLE -> RUN -> FIX -> DONE -> IDLE (or DONE -> RUN on start).
//   IDLE/DONE + start=1: latch sign = is_signed & (A[W-1]^B[W-1]).
//     Latch mcand = (is_signed&A[W-1]) ? -A : A, zero-extended to 2W bits.
//     Latch mplier = (is_signed&B[W-1]) ? -B : B.
//     Clear acc and cnt; go to RUN.
//   Most-negative operand: -(2^(W-1)) is taken as unsigned 2^(W-1). No overflow is possible.
//   RUN, each cycle:
//     acc += mplier[0] ? mcand : 0; mcand <<= 1; mplier >>= 1; cnt++.
//     Go to FIX when cnt==WIDTH-1, or when EARLY_OUT=1 and (mplier>>1)==0.
//     RUN always lasts at least one cycle, including for multiplier==0.
//   FIX (1 cycle): {hi,lo} <= sign ? -acc_final : acc_final, as a 2W-bit two's-complement negate.
//   DONE (1 cycle): done=1, busy=0. A start here is accepted: next cycle is RUN, done falls.
//   hi/lo hold the last result until the next FIX. They are not cleared on start.
//   start while busy=1 is ignored. Operands are not re-sampled.
//   Latency with start accepted at cycle T and EARLY_OUT=0: RUN T+1..T+WIDTH, FIX T+WIDTH+1, done T+WIDTH+2.
//   Latency with EARLY_OUT=1: done at T+k+2, where k = max(1, bit position of the MSB of |B|, plus 1).
//   Operand inputs may change freely after the accepting cycle.
// TESTING
//   Reset: hold reset_n=0 for 2 cycles, with start=1 -> busy=0, done=0, hi=lo=0; no operation launched.
//   Unsigned, EARLY_OUT=0, W=32: 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly T+34.
//   Signed: -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   Signed: 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//   Early-out timing: 5*3 unsigned, EARLY_OUT=1 -> lo=15, done at T+4; 9*0 -> hi=lo=0, done at T+3.
//   Reset and handshake: reset_n low mid-RUN -> no done, hi=lo=0.
//     start pulsed while busy -> ignored; result matches the first operands.
//     start in the DONE cycle -> second result correct, one done pulse each.
//   Random: 1000 random A/B/is_signed at W=32 and W=8 vs. a behavioural reference -> bit-exact hi/lo.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier for the HI/LO unit.
// Handles signed (MULT) and unsigned (MULTU) operands by multiplying
// magnitudes and restoring the sign in a single fix-up cycle. Optional
// early termination stops once no set multiplier bits remain.
`timescale 1ns/1ps
module mult_seq #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic              sign_q;
  logic [PW-1:0]     mcand_q;
  logic [PW-1:0]     acc_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  logic [PW-1:0]     acc_d;
  logic              run_last_d;
  logic              accept_d;

  // Magnitude of an operand. The most negative value maps onto the
  // unsigned 2^(WIDTH-1), so the magnitude always fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] operand_mag(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
    return neg ? -v : v;
  endfunction

  // Restore the product sign with a full-width two's-complement negate.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p,
                                               input logic          neg);
    return neg ? -p : p;
  endfunction

  // Next accumulator value and RUN termination test.
  always_comb begin
    acc_d      = acc_q;
    run_last_d = 1'b0;
    accept_d   = 1'b0;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
    if (cnt_q == CNT_W'(WIDTH - 1)) begin
      run_last_d = 1'b1;
    end
    // Looking at the bits above bit 0 lets the final set bit be consumed
    // in this cycle, so RUN never lasts longer than needed.
    if (EARLY_OUT && (mplier_q[WIDTH-1:1] == '0)) begin
      run_last_d = 1'b1;
    end
    if ((state_q == IDLE || state_q == DONE) && start) begin
      accept_d = 1'b1;
    end
  end

  // Control FSM and datapath; busy/done/hi/lo are registered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept_d) begin
            sign_q   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            mcand_q  <= {{WIDTH{1'b0}},
                         operand_mag(multiplicand, is_signed & multiplicand[WIDTH-1])};
            mplier_q <= operand_mag(multiplier, is_signed & multiplier[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (run_last_d) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          {hi_q, lo_q} <= apply_sign(acc_q, sign_q);
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: three instances (W=32 fixed iterations,
// W=32 early-out, W=8 early-out) with a queue scoreboard of expected products.
`timescale 1ns/1ps
module tb_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_start, a_sgn, a_busy, a_done;
  logic [31:0] a_A, a_B, a_hi, a_lo;
  logic        b_start, b_sgn, b_busy, b_done;
  logic [31:0] b_A, b_B, b_hi, b_lo;
  logic        c_start, c_sgn, c_busy, c_done;
  logic [7:0]  c_A, c_B, c_hi, c_lo;

  mult_seq #(.WIDTH(32), .EARLY_OUT(1'b0)) u_a (
    .clock(clk), .reset_n(rst_n), .start(a_start), .is_signed(a_sgn),
    .multiplicand(a_A), .multiplier(a_B), .busy(a_busy), .done(a_done),
    .hi(a_hi), .lo(a_lo));

  mult_seq #(.WIDTH(32), .EARLY_OUT(1'b1)) u_b (
    .clock(clk), .reset_n(rst_n), .start(b_start), .is_signed(b_sgn),
    .multiplicand(b_A), .multiplier(b_B), .busy(b_busy), .done(b_done),
    .hi(b_hi), .lo(b_lo));

  mult_seq #(.WIDTH(8), .EARLY_OUT(1'b1)) u_c (
    .clock(clk), .reset_n(rst_n), .start(c_start), .is_signed(c_sgn),
    .multiplicand(c_A), .multiplier(c_B), .busy(c_busy), .done(c_done),
    .hi(c_hi), .lo(c_lo));

  int passed = 0;
  int total  = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                        input bit s);
    logic signed [63:0] sx, sy;
    logic [63:0] p;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      p  = sx * sy;
    end else begin
      p = {32'b0, x} * {32'b0, y};
    end
    return p;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input bit s);
    logic signed [15:0] sx, sy;
    logic [15:0] p;
    if (s) begin
      sx = {{8{x[7]}}, x};
      sy = {{8{y[7]}}, y};
      p  = sx * sy;
    end else begin
      p = {8'b0, x} * {8'b0, y};
    end
    return p;
  endfunction

  // Launch one operation on a 32-bit instance (sel=0: u_a, sel=1: u_b) and
  // wait for done. lat = posedges after the accepting edge; -1 on timeout.
  task automatic op32(input bit sel, input logic [31:0] x, input logic [31:0] y,
                      input bit s, output int lat, output logic [63:0] res);
    if (sel) begin b_start = 1; b_A = x; b_B = y; b_sgn = s; end
    else     begin a_start = 1; a_A = x; a_B = y; a_sgn = s; end
    @(posedge clk); #1;
    if (sel) begin b_start = 0; b_A = ~x; b_B = ~y; b_sgn = ~s; end
    else     begin a_start = 0; a_A = ~x; a_B = ~y; a_sgn = ~s; end
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (sel ? b_done : a_done) begin
        lat = i;
        res = sel ? {b_hi, b_lo} : {a_hi, a_lo};
        break;
      end
    end
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit s,
                     output int lat, output logic [15:0] res);
    c_start = 1; c_A = x; c_B = y; c_sgn = s;
    @(posedge clk); #1;
    c_start = 0; c_A = ~x; c_B = ~y; c_sgn = ~s;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (c_done) begin
        lat = i;
        res = {c_hi, c_lo};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    a_start = 1; a_A = 32'd3; a_B = 32'd5; a_sgn = 0;
    b_start = 1; b_A = 32'd3; b_B = 32'd5; b_sgn = 0;
    c_start = 1; c_A = 8'd3;  c_B = 8'd5;  c_sgn = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_busy !== 1'b0) $display("FAIL reset_a_busy got=%b want=0", a_busy); else passed++;
    total++; if (a_done !== 1'b0) $display("FAIL reset_a_done got=%b want=0", a_done); else passed++;
    total++; if ({a_hi, a_lo} !== 64'd0) $display("FAIL reset_a_hilo got=%h want=0", {a_hi, a_lo}); else passed++;
    total++; if ({b_busy, b_done} !== 2'b00) $display("FAIL reset_b_ctl got=%b want=00", {b_busy, b_done}); else passed++;
    total++; if ({c_busy, c_done, c_hi, c_lo} !== 18'd0) $display("FAIL reset_c got=%h want=0", {c_busy, c_done, c_hi, c_lo}); else passed++;
    a_start = 0; b_start = 0; c_start = 0;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({a_busy, b_busy, c_busy} !== 3'b000) $display("FAIL reset_no_launch got=%b want=000", {a_busy, b_busy, c_busy}); else passed++;
  endtask

  task automatic test_unsigned_full();
    int lat;
    logic [63:0] res, exp;
    q32.push_back(64'hFFFFFFFE_00000001);
    op32(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, res);
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL umax_result got=%h want=%h", res, exp); else passed++;
    total++; if (lat !== 33) $display("FAIL umax_latency got=%0d want=33", lat); else passed++;
    @(posedge clk); #1;
    total++; if ({a_done, a_busy} !== 2'b00) $display("FAIL umax_done_pulse got=%b want=00", {a_done, a_busy}); else passed++;
    total++; if ({a_hi, a_lo} !== exp) $display("FAIL umax_hold got=%h want=%h", {a_hi, a_lo}, exp); else passed++;
  endtask

  task automatic test_signed();
    int lat;
    logic [63:0] res, exp;
    q32.push_back(64'hFFFFFFFF_FFFFFFEB);
    op32(0, -32'sd7, 32'd3, 1, lat, res);
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL signed_m7x3 got=%h want=%h", res, exp); else passed++;
    q32.push_back(64'h40000000_00000000);
    op32(0, 32'h80000000, 32'h80000000, 1, lat, res);
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL signed_minxmin got=%h want=%h", res, exp); else passed++;
    q32.push_back(ref32(32'h80000000, 32'h00000001, 1'b1));
    op32(1, 32'h80000000, 32'h00000001, 1, lat, res);
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL signed_minx1 got=%h want=%h", res, exp); else passed++;
  endtask

  task automatic test_early_out();
    int lat;
    logic [63:0] res, exp;
    q32.push_back(64'd15);
    op32(1, 32'd5, 32'd3, 0, lat, res);
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL early_5x3 got=%h want=%h", res, exp); else passed++;
    total++; if (lat !== 3) $display("FAIL early_5x3_latency got=%0d want=3", lat); else passed++;
    q32.push_back(64'd0);
    op32(1, 32'd9, 32'd0, 0, lat, res);
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL early_9x0 got=%h want=%h", res, exp); else passed++;
    total++; if (lat !== 2) $display("FAIL early_9x0_latency got=%0d want=2", lat); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int dones;
    a_start = 1; a_A = 32'h12345678; a_B = 32'h9ABCDEF0; a_sgn = 0;
    @(posedge clk); #1;
    a_start = 0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    total++; if (a_busy !== 1'b0) $display("FAIL midrun_busy got=%b want=0", a_busy); else passed++;
    total++; if ({a_hi, a_lo} !== 64'd0) $display("FAIL midrun_hilo got=%h want=0", {a_hi, a_lo}); else passed++;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (a_done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL midrun_no_done got=%0d want=0", dones); else passed++;
  endtask

  task automatic test_start_while_busy();
    int lat, dones;
    logic [63:0] res, exp;
    q32.push_back(ref32(32'd1000, 32'd3, 1'b0));
    a_start = 1; a_A = 32'd1000; a_B = 32'd3; a_sgn = 0;
    @(posedge clk); #1;
    a_start = 0; a_A = 32'd0; a_B = 32'd0;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 60; i++) begin
      if (i == 4) begin a_start = 1; a_A = 32'd7; a_B = 32'd7; a_sgn = 1; end
      if (i == 5) begin a_start = 0; end
      @(posedge clk); #1;
      if (a_done) begin lat = i; res = {a_hi, a_lo}; break; end
    end
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL busy_start_result got=%h want=%h", res, exp); else passed++;
    total++; if (lat !== 33) $display("FAIL busy_start_latency got=%0d want=33", lat); else passed++;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (a_done || a_busy) dones++;
    end
    total++; if (dones !== 0) $display("FAIL busy_start_relaunch got=%0d want=0", dones); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, dones;
    logic [63:0] res, exp;
    q32.push_back(ref32(32'd5, 32'd3, 1'b0));
    op32(1, 32'd5, 32'd3, 0, lat, res);
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL b2b_first got=%h want=%h", res, exp); else passed++;
    // Still in the DONE cycle: launch the next operation immediately.
    q32.push_back(ref32(-32'sd100, 32'd200, 1'b1));
    b_start = 1; b_A = -32'sd100; b_B = 32'd200; b_sgn = 1;
    @(posedge clk); #1;
    b_start = 0; b_A = 32'd1; b_B = 32'd1; b_sgn = 0;
    total++; if ({b_done, b_busy} !== 2'b01) $display("FAIL b2b_handover got=%b want=01", {b_done, b_busy}); else passed++;
    lat = -1;
    res = 'x;
    dones = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (b_done) begin dones++; lat = i; res = {b_hi, b_lo}; break; end
    end
    exp = q32.pop_front();
    total++; if (res !== exp) $display("FAIL b2b_second got=%h want=%h", res, exp); else passed++;
    total++; if (lat !== 9) $display("FAIL b2b_latency got=%0d want=9", lat); else passed++;
    @(posedge clk); #1;
    if (b_done) dones++;
    total++; if (dones !== 1) $display("FAIL b2b_done_count got=%0d want=1", dones); else passed++;
  endtask

  task automatic test_random();
    int lat, errs32, errs8;
    logic [31:0] x, y;
    logic [7:0]  x8, y8;
    bit s;
    logic [63:0] res, exp;
    logic [15:0] res8, exp8;
    errs32 = 0;
    errs8  = 0;
    for (int n = 0; n < 1000; n++) begin
      x = $urandom();
      y = $urandom();
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h0;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      q32.push_back(ref32(x, y, s));
      op32(1, x, y, s, lat, res);
      exp = q32.pop_front();
      total++;
      if (res !== exp) begin
        errs32++;
        if (errs32 <= 5) $display("FAIL rand32 a=%h b=%h s=%0d got=%h want=%h", x, y, s, res, exp);
      end else passed++;
    end
    for (int n = 0; n < 1000; n++) begin
      x8 = 8'($urandom());
      y8 = 8'($urandom());
      s  = 1'($urandom_range(0, 1));
      q8.push_back(ref8(x8, y8, s));
      op8(x8, y8, s, lat, res8);
      exp8 = q8.pop_front();
      total++;
      if (res8 !== exp8) begin
        errs8++;
        if (errs8 <= 5) $display("FAIL rand8 a=%h b=%h s=%0d got=%h want=%h", x8, y8, s, res8, exp8);
      end else passed++;
    end
  endtask

  initial begin
    rst_n = 0;
    a_start = 0; a_sgn = 0; a_A = 0; a_B = 0;
    b_start = 0; b_sgn = 0; b_A = 0; b_B = 0;
    c_start = 0; c_sgn = 0; c_A = 0; c_B = 0;
    test_reset();
    test_unsigned_full();
    test_signed();
    test_early_out();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
